cache_fill_ctrl: RTL and testbench

- Sequential back end of the 4-entry fully associative processor cache.
- Holds the entry store: address tags, data, 2-bit LRU counters and valid bits.
- Exports the store to the combinational hit/victim lookup unit, and consumes its hit/sel/dec decision.
- Services read misses from main memory; write-through on writes, with no write-allocate.

---
 rtl/cache_pkg.sv | 26 ++
 rtl/cache_fill_ctrl_lru_update.sv | 23 ++
 rtl/cache_fill_ctrl.sv | 178 +++++++++++++++++
 tb/tb_cache_fill_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// cache_pkg: shared definitions for the 4-entry fully associative cache back end.
//   NUM_ENTRIES  number of cache entries
//   CNT_MAX      LRU counter value given to the most recently used entry
//   ADDR_W/DATA_W default address/data widths (entry_t is sized by them)
//   fill_state_t controller FSM states
//   entry_t      one entry of the store: tag, data, LRU counter, valid
package cache_pkg;
  localparam int         NUM_ENTRIES = 4;
  localparam logic [1:0] CNT_MAX     = 2'b11;
  localparam int         ADDR_W      = 8;
  localparam int         DATA_W      = 8;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_FILL_WAIT  = 2'd1,
    ST_WRITE_WAIT = 2'd2,
    ST_RESP       = 2'd3
  } fill_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] tag;
    logic [DATA_W-1:0] data;
    logic [1:0]        cnt;
    logic              valid;
  } entry_t;
endpackage

// File: rtl/cache_fill_ctrl_lru_update.sv
// lru_update: combinational LRU counter next-value block.
//   i_sel  entry being touched (set to CNT_MAX)
//   i_dec  per-entry decrement enables (ignored for i_sel)
//   i_cnt  current counters
//   o_cnt  next counters; decrements saturate at 0, never wrap
module lru_update
  import cache_pkg::*;
(
  input  logic [1:0]                  i_sel,
  input  logic [NUM_ENTRIES-1:0]      i_dec,
  input  logic [NUM_ENTRIES-1:0][1:0] i_cnt,
  output logic [NUM_ENTRIES-1:0][1:0] o_cnt
);
  always_comb begin
    o_cnt = i_cnt;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (i_sel == 2'(i))
        o_cnt[i] = CNT_MAX;
      else if (i_dec[i] && (i_cnt[i] != 2'd0))
        o_cnt[i] = i_cnt[i] - 2'd1;
    end
  end
endmodule

// File: rtl/cache_fill_ctrl.sv
// cache_fill_ctrl: sequential back end of the 4-entry fully associative cache.
// Holds the entry store, exports it to the external hit/victim lookup unit,
// and acts on its hit/sel/dec decision. Read misses fill from memory;
// writes go through to memory, with no allocation on a write miss.
//   clk/rst             clock, async active-high reset
//   cpu_*               CPU request/response (req pulse, done pulse, busy)
//   hit_in/sel_in/dec_in lookup result, only looked at when a request is accepted
//   entry_addrs/cnt/valid entry store, to the lookup unit
//   mem_*               memory port; mem_req held until mem_ack
// Build option: CACHE_FILL_STATS_EN adds saturating hit_count/miss_count outputs.
module cache_fill_ctrl
  import cache_pkg::*;
#(
  parameter int d_width = DATA_W,
  parameter int a_width = ADDR_W
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               cpu_req,
  input  logic                               cpu_we,
  input  logic [a_width-1:0]                 cpu_addr,
  input  logic [d_width-1:0]                 cpu_wdata,
  output logic [d_width-1:0]                 cpu_rdata,
  output logic                               cpu_done,
  output logic                               cpu_busy,
  input  logic                               hit_in,
  input  logic [1:0]                         sel_in,
  input  logic [NUM_ENTRIES-1:0]             dec_in,
  output logic [NUM_ENTRIES-1:0][a_width-1:0] entry_addrs,
  output logic [NUM_ENTRIES-1:0][1:0]        cnt,
  output logic [NUM_ENTRIES-1:0]             valid,
  output logic                               mem_req,
  output logic                               mem_we,
  output logic [a_width-1:0]                 mem_addr,
  output logic [d_width-1:0]                 mem_wdata,
  input  logic [d_width-1:0]                 mem_rdata,
  input  logic                               mem_ack
`ifdef CACHE_FILL_STATS_EN
  ,
  output logic [15:0]                        hit_count,
  output logic [15:0]                        miss_count
`endif
);
  // The entry store is built from entry_t, whose fields use the package widths.
  if ((a_width != ADDR_W) || (d_width != DATA_W)) begin : g_width_guard
    $error("cache_fill_ctrl: a_width/d_width must match cache_pkg ADDR_W/DATA_W");
  end

  fill_state_t                       r_state, w_state_nxt;
  entry_t [NUM_ENTRIES-1:0]          r_ent;
  logic   [a_width-1:0]              r_addr;
  logic   [1:0]                      r_sel;
  logic   [NUM_ENTRIES-1:0]          r_dec;
  logic                              w_accept;
  logic   [1:0]                      w_lru_sel;
  logic   [NUM_ENTRIES-1:0]          w_lru_dec;
  logic   [NUM_ENTRIES-1:0][1:0]     w_cnt_cur, w_cnt_nxt;

  assign w_accept = (r_state == ST_IDLE) && cpu_req;

  // Live lookup result on acceptance; the latched copy is used for the fill.
  assign w_lru_sel = (r_state == ST_IDLE) ? sel_in : r_sel;
  assign w_lru_dec = (r_state == ST_IDLE) ? dec_in : r_dec;

  always_comb begin
    w_cnt_cur   = '0;
    entry_addrs = '0;
    valid       = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      w_cnt_cur[i]   = r_ent[i].cnt;
      entry_addrs[i] = r_ent[i].tag;
      valid[i]       = r_ent[i].valid;
    end
  end
  assign cnt = w_cnt_cur;

  lru_update u_lru (
    .i_sel (w_lru_sel),
    .i_dec (w_lru_dec),
    .i_cnt (w_cnt_cur),
    .o_cnt (w_cnt_nxt)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (cpu_req) begin
        if (cpu_we)      w_state_nxt = ST_WRITE_WAIT;
        else if (hit_in) w_state_nxt = ST_RESP;
        else             w_state_nxt = ST_FILL_WAIT;
      end
      ST_FILL_WAIT, ST_WRITE_WAIT: if (mem_ack) w_state_nxt = ST_RESP;
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    cpu_done = (r_state == ST_RESP);
    cpu_busy = (r_state != ST_IDLE);
  end

  // Entry store, request latches and registered memory/CPU data outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ent     <= '0;
      r_addr    <= '0;
      r_sel     <= '0;
      r_dec     <= '0;
      cpu_rdata <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (cpu_req) begin
          r_addr <= cpu_addr;
          r_sel  <= sel_in;
          r_dec  <= dec_in;
          if (cpu_we) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= cpu_addr;
            mem_wdata <= cpu_wdata;
            if (hit_in) begin
              r_ent[sel_in].data <= cpu_wdata;
              for (int i = 0; i < NUM_ENTRIES; i++) r_ent[i].cnt <= w_cnt_nxt[i];
            end
          end else if (hit_in) begin
            cpu_rdata <= r_ent[sel_in].data;
            for (int i = 0; i < NUM_ENTRIES; i++) r_ent[i].cnt <= w_cnt_nxt[i];
          end else begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= cpu_addr;
          end
        end
        ST_FILL_WAIT: if (mem_ack) begin
          r_ent[r_sel].tag   <= r_addr;
          r_ent[r_sel].data  <= mem_rdata;
          r_ent[r_sel].valid <= 1'b1;
          for (int i = 0; i < NUM_ENTRIES; i++) r_ent[i].cnt <= w_cnt_nxt[i];
          cpu_rdata <= mem_rdata;
          mem_req   <= 1'b0;
        end
        ST_WRITE_WAIT: if (mem_ack) begin
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef CACHE_FILL_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (w_accept) begin
      if (hit_in) begin
        if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
      end else begin
        if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
      end
    end
  end
`endif
endmodule

// File: tb/tb_cache_fill_ctrl.sv
module tb_cache_fill_ctrl;
  logic            clk = 1'b0;
  logic            rst;
  logic            cpu_req, cpu_we;
  logic [7:0]      cpu_addr, cpu_wdata, cpu_rdata;
  logic            cpu_done, cpu_busy;
  logic            hit_in;
  logic [1:0]      sel_in;
  logic [3:0]      dec_in;
  logic [3:0][7:0] entry_addrs;
  logic [3:0][1:0] cnt;
  logic [3:0]      valid;
  logic            mem_req, mem_we;
  logic [7:0]      mem_addr, mem_wdata, mem_rdata;
  logic            mem_ack;
`ifdef CACHE_FILL_STATS_EN
  logic [15:0]     hit_count, miss_count;
`endif

  always #5 clk = ~clk;

  cache_fill_ctrl dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_busy(cpu_busy),
    .hit_in(hit_in), .sel_in(sel_in), .dec_in(dec_in),
    .entry_addrs(entry_addrs), .cnt(cnt), .valid(valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
`ifdef CACHE_FILL_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: the entry store as plain arrays plus outcome tallies.
  logic [7:0] m_tag [4];
  logic [7:0] m_data[4];
  int         m_cnt [4];
  logic [3:0] m_valid;
  int         m_hits, m_miss;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void m_reset();
    for (int i = 0; i < 4; i++) begin
      m_tag[i] = '0; m_data[i] = '0; m_cnt[i] = 0;
    end
    m_valid = '0; m_hits = 0; m_miss = 0;
  endfunction

  // Touched entry becomes most recent (3); others flagged in dec lose one, floor 0.
  function automatic void m_touch(input int s, input logic [3:0] d);
    for (int i = 0; i < 4; i++) begin
      if (i == s) m_cnt[i] = 3;
      else if (d[i] && m_cnt[i] > 0) m_cnt[i] = m_cnt[i] - 1;
    end
  endfunction

  task automatic check_store(input string where);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s tag%0d", where, i), 32'(entry_addrs[i]), 32'(m_tag[i]));
      chk($sformatf("%s cnt%0d", where, i), 32'(cnt[i]), 32'(m_cnt[i]));
    end
    chk({where, " valid"}, 32'(valid), 32'(m_valid));
`ifdef CACHE_FILL_STATS_EN
    chk({where, " hit_count"},  32'(hit_count),  (m_hits > 65535) ? 32'hFFFF : 32'(m_hits));
    chk({where, " miss_count"}, 32'(miss_count), (m_miss > 65535) ? 32'hFFFF : 32'(m_miss));
`endif
  endtask

  task automatic scramble_lookup();
    hit_in = 1'($urandom); sel_in = 2'($urandom); dec_in = 4'($urandom);
    cpu_we = 1'($urandom); cpu_addr = 8'($urandom); cpu_wdata = 8'($urandom);
  endtask

  // One CPU transaction, with memory responding after lat cycles.
  // poke: pulse cpu_req with junk while the memory wait is in progress.
  task automatic do_req(input logic we, input logic [7:0] addr, input logic [7:0] wd,
                        input logic hit, input logic [1:0] sel, input logic [3:0] dec,
                        input int lat, input logic [7:0] rd, input bit poke);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    hit_in = hit; sel_in = sel; dec_in = dec;
    @(negedge clk);
    cpu_req = 1'b0;
    scramble_lookup();
    if (hit) m_hits++; else m_miss++;
    if (!we && hit) begin
      chk("hit done", 32'(cpu_done), 32'd1);
      chk("hit rdata", 32'(cpu_rdata), 32'(m_data[sel]));
      chk("hit no mem_req", 32'(mem_req), 32'd0);
      m_touch(sel, dec);
    end else begin
      chk("mem_req", 32'(mem_req), 32'd1);
      chk("mem_we", 32'(mem_we), 32'(we));
      chk("mem_addr", 32'(mem_addr), 32'(addr));
      if (we) chk("mem_wdata", 32'(mem_wdata), 32'(wd));
      chk("busy", 32'(cpu_busy), 32'd1);
      if (we && hit) begin
        m_data[sel] = wd;
        m_touch(sel, dec);
      end
      for (int k = 0; k < lat; k++) begin
        if (poke) cpu_req = 1'b1;
        @(negedge clk);
        cpu_req = 1'b0;
        scramble_lookup();
        chk("wait mem_req held", 32'(mem_req), 32'd1);
        chk("wait mem_addr held", 32'(mem_addr), 32'(addr));
        chk("wait no done", 32'(cpu_done), 32'd0);
      end
      mem_ack = 1'b1; mem_rdata = rd;
      @(negedge clk);
      mem_ack = 1'b0; mem_rdata = 8'($urandom);
      if (!we) begin
        m_tag[sel] = addr; m_data[sel] = rd; m_valid[sel] = 1'b1;
        m_touch(sel, dec);
        chk("fill rdata", 32'(cpu_rdata), 32'(rd));
      end
      chk("ack done", 32'(cpu_done), 32'd1);
      chk("ack mem_req drop", 32'(mem_req), 32'd0);
      chk("ack mem_we drop", 32'(mem_we), 32'd0);
    end
    @(negedge clk);
    chk("done one pulse", 32'(cpu_done), 32'd0);
    chk("idle not busy", 32'(cpu_busy), 32'd0);
    check_store("post");
  endtask

  initial begin
    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    hit_in = 1'b0; sel_in = '0; dec_in = '0; mem_rdata = '0; mem_ack = 1'b0;
    m_reset();
    repeat (3) @(negedge clk);
    chk("rst busy", 32'(cpu_busy), 32'd0);
    chk("rst done", 32'(cpu_done), 32'd0);
    chk("rst rdata", 32'(cpu_rdata), 32'd0);
    chk("rst mem_req", 32'(mem_req), 32'd0);
    chk("rst mem_addr", 32'(mem_addr), 32'd0);
    check_store("rst");
    rst = 1'b0;

    // Directed: miss/fill, hit, further fills, write hit, write miss, busy poke.
    do_req(1'b0, 8'h10, 8'h00, 1'b0, 2'd0, 4'b0111, 3, 8'hA5, 1'b0);
    do_req(1'b0, 8'h10, 8'h00, 1'b1, 2'd0, 4'b0000, 0, 8'h00, 1'b0);
    do_req(1'b0, 8'h20, 8'h00, 1'b0, 2'd1, 4'b0001, 1, 8'h3C, 1'b0);
    do_req(1'b0, 8'h30, 8'h00, 1'b0, 2'd3, 4'b0011, 0, 8'h5A, 1'b0);
    do_req(1'b0, 8'h30, 8'h00, 1'b1, 2'd3, 4'b0011, 0, 8'h00, 1'b0);
    do_req(1'b1, 8'h20, 8'hC3, 1'b1, 2'd1, 4'b1001, 2, 8'h00, 1'b0);
    do_req(1'b0, 8'h20, 8'h00, 1'b1, 2'd1, 4'b0000, 0, 8'h00, 1'b0);
    do_req(1'b1, 8'h77, 8'h99, 1'b0, 2'd2, 4'b1111, 2, 8'h00, 1'b0);
    do_req(1'b0, 8'h44, 8'h00, 1'b0, 2'd2, 4'b1011, 3, 8'h61, 1'b1);

    // Reset in the middle of a fill, then a late ack that must be ignored.
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h55; hit_in = 1'b0; sel_in = 2'd2; dec_in = 4'hF;
    @(negedge clk);
    cpu_req = 1'b0;
    chk("pre-rst mem_req", 32'(mem_req), 32'd1);
    #2 rst = 1'b1;
    #1;
    m_reset();
    chk("mid rst mem_req", 32'(mem_req), 32'd0);
    chk("mid rst mem_addr", 32'(mem_addr), 32'd0);
    chk("mid rst busy", 32'(cpu_busy), 32'd0);
    check_store("mid rst");
    @(negedge clk);
    rst = 1'b0; mem_ack = 1'b1; mem_rdata = 8'hEE;
    @(negedge clk);
    mem_ack = 1'b0;
    @(negedge clk);
    chk("late ack busy", 32'(cpu_busy), 32'd0);
    chk("late ack done", 32'(cpu_done), 32'd0);
    chk("late ack rdata", 32'(cpu_rdata), 32'd0);
    check_store("late ack");

    // Randomized traffic against the model.
    for (int t = 0; t < 300; t++) begin
      do_req(1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
             2'($urandom), 4'($urandom), int'($urandom_range(0, 3)), 8'($urandom),
             1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Safety net so a stuck run still ends with a report.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete (compared %0d)", n_cmp);
    $fatal(1, "timeout");
  end
endmodule
